// File: rtl/wb_bram_pkg.sv
// Shared definitions for the Wishbone BRAM controller with sequential-read prefetch.
package wb_bram_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_WR_WAIT = 3'd2,
    S_ACK     = 3'd3,
    S_PF_WAIT = 3'd4
  } state_t;

  localparam logic [31:0] DEF_ADDR_BASE = 32'h3800_0000;
  localparam logic [31:0] DEF_ADDR_MASK = 32'hFFF0_0000;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/wb_prefetch_buf.sv
// One-entry prefetch buffer: hit compare, fill/invalidate, and byte-merge of writes
// to the buffered word.
module wb_prefetch_buf
  import wb_bram_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_inv,
  input  logic          i_fill,
  input  logic [AW-1:0] i_fill_addr,
  input  logic [31:0]   i_fill_dat,
  input  logic          i_wr,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [3:0]    i_wr_sel,
  input  logic [31:0]   i_wr_dat,
  input  logic [AW-1:0] i_lookup_addr,
  output logic          o_hit,
  output logic [31:0]   o_dat
);

  logic          r_vld;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_dat;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld  <= 1'b0;
      r_addr <= '0;
      r_dat  <= '0;
    end else if (i_inv) begin
      r_vld <= 1'b0;
    end else if (i_fill) begin
      r_vld  <= 1'b1;
      r_addr <= i_fill_addr;
      r_dat  <= i_fill_dat;
    end else if (i_wr && (i_wr_addr == r_addr)) begin
      // Merge even while invalid so the entry can never hold stale bytes.
      for (int b = 0; b < 4; b++) begin
        if (i_wr_sel[b]) r_dat[8*b +: 8] <= i_wr_dat[8*b +: 8];
      end
    end
  end

  assign o_hit = r_vld && (r_addr == i_lookup_addr);
  assign o_dat = r_dat;

endmodule

// File: rtl/wb_bram_prefetch_ctrl.sv
// Wishbone slave in front of a 1-cycle-read BRAM with programmable read/write wait
// states, base/mask decode and a one-entry next-word prefetch buffer.
module wb_bram_prefetch_ctrl
  import wb_bram_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = DEF_ADDR_BASE,
  parameter logic [31:0] ADDR_MASK   = DEF_ADDR_MASK,
  parameter int          DEPTH       = 1024,
  parameter int          RD_DELAY    = 10,
  parameter int          WR_DELAY    = 10,
  parameter bit          PREFETCH_EN = 1'b1
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_dat_i,
  input  logic [31:0]             wbs_adr_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic                    bram_en,
  output logic [3:0]              bram_we,
  output logic [clog2(DEPTH)-1:0] bram_addr,
  output logic [31:0]             bram_di,
  input  logic [31:0]             bram_do,
  output logic [15:0]             pf_hit_cnt
);

  localparam int AW = clog2(DEPTH);
  localparam int MAX_DELAY = (RD_DELAY > WR_DELAY) ? RD_DELAY : WR_DELAY;
  localparam int CW = clog2(MAX_DELAY + 1) + 1;

  state_t        r_state, w_nxt;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_dat_o;
  logic          r_is_rd;
  logic          r_pf_trig;
  logic [15:0]   r_hit_cnt;

  logic [AW-1:0] w_idx;
  logic          w_valid, w_pf_hit, w_pf_go, w_accept, w_cap;
  logic          w_en, w_pf_inv, w_pf_fill, w_pf_wr;
  logic [3:0]    w_we;
  logic [AW-1:0] w_addr;
  logic [31:0]   w_pf_dat;

  assign w_idx   = wbs_adr_i[AW+1:2];
  assign w_valid = wbs_cyc_i && wbs_stb_i && ((wbs_adr_i & ADDR_MASK) == ADDR_BASE);
  assign w_pf_go = PREFETCH_EN && r_pf_trig && !w_valid;

  always_comb begin
    w_nxt     = r_state;
    w_en      = 1'b0;
    w_we      = 4'h0;
    w_addr    = r_idx;
    w_cap     = 1'b0;
    w_accept  = 1'b0;
    w_pf_inv  = 1'b0;
    w_pf_fill = 1'b0;
    w_pf_wr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_addr = w_idx;
        if (w_valid) begin
          w_accept = 1'b1;
          if (wbs_we_i) begin
            w_nxt = S_WR_WAIT;
          end else if (w_pf_hit) begin
            w_nxt = S_ACK;
          end else begin
            w_nxt = S_RD_WAIT;
            // With a single wait state the BRAM read must start in the accept cycle.
            if (RD_DELAY == 1) w_en = 1'b1;
          end
        end else if (w_pf_go) begin
          w_nxt    = S_PF_WAIT;
          w_pf_inv = 1'b1;
        end
      end
      S_RD_WAIT: begin
        if (!wbs_cyc_i) begin
          w_nxt = S_IDLE;
        end else begin
          if (r_cnt == CW'(RD_DELAY - 1)) w_en = 1'b1;
          if (r_cnt == CW'(RD_DELAY)) begin
            w_cap = 1'b1;
            w_nxt = S_ACK;
          end
        end
      end
      S_WR_WAIT: begin
        if (!wbs_cyc_i) begin
          w_nxt = S_IDLE;
        end else if (r_cnt == CW'(WR_DELAY)) begin
          w_en    = 1'b1;
          w_we    = wbs_sel_i;
          w_pf_wr = 1'b1;
          w_nxt   = S_ACK;
        end
      end
      S_ACK: w_nxt = S_IDLE;
      S_PF_WAIT: begin
        if (r_cnt == CW'(RD_DELAY - 1)) w_en = 1'b1;
        if (r_cnt == CW'(RD_DELAY)) begin
          w_pf_fill = 1'b1;
          w_nxt     = S_IDLE;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_dat_o   <= '0;
      r_is_rd   <= 1'b0;
      r_pf_trig <= 1'b0;
      r_hit_cnt <= '0;
    end else begin
      r_state   <= w_nxt;
      r_pf_trig <= (r_state == S_ACK) && r_is_rd;
      if (w_accept) begin
        r_idx   <= w_idx;
        r_is_rd <= !wbs_we_i;
        r_cnt   <= CW'(1);
        if (!wbs_we_i && w_pf_hit) begin
          r_dat_o <= w_pf_dat;
          if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
        end
      end else if (w_pf_inv) begin
        r_idx <= r_idx + AW'(1);
        r_cnt <= '0;
      end else if (r_state == S_RD_WAIT || r_state == S_WR_WAIT || r_state == S_PF_WAIT) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_cap) r_dat_o <= bram_do;
    end
  end

  wb_prefetch_buf #(.AW(AW)) u_pf (
    .i_clk         (wb_clk_i),
    .i_rst         (wb_rst_i),
    .i_inv         (w_pf_inv),
    .i_fill        (w_pf_fill),
    .i_fill_addr   (r_idx),
    .i_fill_dat    (bram_do),
    .i_wr          (w_pf_wr),
    .i_wr_addr     (r_idx),
    .i_wr_sel      (wbs_sel_i),
    .i_wr_dat      (wbs_dat_i),
    .i_lookup_addr (w_idx),
    .o_hit         (w_pf_hit),
    .o_dat         (w_pf_dat)
  );

  assign wbs_ack_o  = (r_state == S_ACK);
  assign wbs_dat_o  = r_dat_o;
  assign bram_en    = w_en && !wb_rst_i;
  assign bram_we    = wb_rst_i ? 4'h0 : w_we;
  assign bram_addr  = w_addr;
  assign bram_di    = wbs_dat_i;
  assign pf_hit_cnt = r_hit_cnt;

endmodule

// File: tb/tb_wb_bram_prefetch_ctrl.sv
// Directed bench: scoreboard of expected ack latency/data per Wishbone transfer.
module tb_wb_bram_prefetch_ctrl;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int RD    = 10;
  localparam int WR    = 10;

  logic          clk = 1'b0;
  logic          rst, stb, cyc, we;
  logic [3:0]    sel;
  logic [31:0]   dat_i, adr;
  logic          ack;
  logic [31:0]   dat_o;
  logic          bram_en;
  logic [3:0]    bram_we;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_di;
  logic [31:0]   bram_do;
  logic [15:0]   hit_cnt;

  logic [31:0] mem     [DEPTH];
  logic [31:0] exp_mem [DEPTH];
  logic [31:0] last_rd;
  int          checks = 0, errors = 0;
  int          en_cnt = 0, ack_cnt = 0;
  int          exp_hits = 0;

  typedef struct {
    logic        is_rd;
    logic [31:0] dat;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  wb_bram_prefetch_ctrl #(
    .DEPTH(DEPTH), .RD_DELAY(RD), .WR_DELAY(WR), .PREFETCH_EN(1'b1)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr),
    .wbs_ack_o(ack), .wbs_dat_o(dat_o), .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_di(bram_di), .bram_do(bram_do), .pf_hit_cnt(hit_cnt)
  );

  always @(posedge clk) begin
    if (bram_en) begin
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_di[8*b +: 8];
      bram_do <= mem[bram_addr];
      en_cnt++;
    end
    if (ack) ack_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int lat, input string tag);
    exp_t        e;
    int          n;
    logic        got;
    logic [AW-1:0] wd;
    wd      = a[AW+1:2];
    e.is_rd = !w;
    e.lat   = lat;
    e.dat   = w ? last_rd : exp_mem[wd];
    sb.push_back(e);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    n = 0; got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk); #1; n++;
      if (ack) got = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    e = sb.pop_front();
    chk({tag, "_ack"}, 32'(got), 32'd1);
    chk({tag, "_lat"}, 32'(n), 32'(e.lat));
    chk({tag, "_dat"}, dat_o, e.dat);
    if (e.is_rd) last_rd = e.dat;
    else for (int b = 0; b < 4; b++) if (s[b]) exp_mem[wd][8*b +: 8] = d[8*b +: 8];
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(ack), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int e0, a0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'hC0DE_0000 | i;
      exp_mem[i] = 32'hC0DE_0000 | i;
    end
    last_rd = 32'h0;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; dat_i = '0; adr = '0;
    idle(3);
    rst = 1'b0;
    idle(1);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", dat_o, 32'h0);
    chk("rst_hits", 32'(hit_cnt), 32'd0);

    // Reset four cycles into a read miss.
    a0 = ack_cnt;
    cyc = 1'b1; stb = 1'b1; adr = 32'h3800_0000;
    idle(4);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    idle(1);
    rst = 1'b0;
    chk("rst2_en", 32'(bram_en), 32'd0);
    chk("rst2_ack", 32'(ack), 32'd0);
    chk("rst2_pfvld", 32'(dut.u_pf.r_vld), 32'd0);
    idle(20);
    chk("rst2_noack", 32'(ack_cnt), 32'(a0));

    // Write then miss read.
    xfer(1'b1, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF, WR + 1, "wr4");
    chk("mem4", mem[4], 32'hDEAD_BEEF);
    xfer(1'b0, 32'h3800_0010, 32'h0, 4'hF, RD + 1, "rd4");
    idle(14);

    // Sequential read hits the prefetched next word.
    xfer(1'b0, 32'h3800_0010, 32'h0, 4'hF, RD + 1, "rd4b");
    idle(14);
    xfer(1'b0, 32'h3800_0014, 32'h0, 4'hF, 1, "hit5");
    exp_hits++;
    chk("hits1", 32'(hit_cnt), 32'(exp_hits));
    idle(14);

    // Partial write into the buffered word stays coherent.
    xfer(1'b0, 32'h3800_0010, 32'h0, 4'hF, RD + 1, "rd4c");
    idle(14);
    xfer(1'b1, 32'h3800_0014, 32'h0000_00AA, 4'b0001, WR + 1, "wr5");
    xfer(1'b0, 32'h3800_0014, 32'h0, 4'hF, 1, "hit5b");
    exp_hits++;
    chk("merge5", last_rd, 32'hC0DE_00AA);
    chk("hits2", 32'(hit_cnt), 32'(exp_hits));
    idle(14);

    // Index wrap DEPTH-1 -> 0.
    xfer(1'b0, 32'h3800_0FFC, 32'h0, 4'hF, RD + 1, "rd1023");
    idle(14);
    xfer(1'b0, 32'h3800_0000, 32'h0, 4'hF, 1, "hitwrap");
    exp_hits++;
    chk("hits3", 32'(hit_cnt), 32'(exp_hits));
    idle(14);

    // Undecoded window: never acked, BRAM untouched.
    e0 = en_cnt; a0 = ack_cnt;
    cyc = 1'b1; stb = 1'b1; adr = 32'h3010_0000;
    idle(50);
    cyc = 1'b0; stb = 1'b0;
    chk("undec_en", 32'(en_cnt), 32'(e0));
    chk("undec_ack", 32'(ack_cnt), 32'(a0));
    idle(2);

    // Read of the target arriving 3 cycles into PF_WAIT.
    xfer(1'b0, 32'h3800_0020, 32'h0, 4'hF, RD + 1, "rd8");
    idle(4);
    xfer(1'b0, 32'h3800_0024, 32'h0, 4'hF, RD + 2 - 3, "pfw9");
    exp_hits++;
    chk("hits4", 32'(hit_cnt), 32'(exp_hits));
    idle(14);

    // Write aborted before its wait states elapse.
    a0 = ack_cnt;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3800_001C; dat_i = 32'h1234_5678; sel = 4'hF;
    idle(5);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    idle(20);
    chk("abort_ack", 32'(ack_cnt), 32'(a0));
    chk("abort_mem", mem[7], exp_mem[7]);
    xfer(1'b0, 32'h3800_001C, 32'h0, 4'hF, RD + 1, "rd7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
